// File: rtl/exp_taylor_engine_pkg.sv
// Shared Q-format defaults, FSM encoding and 1/k coefficient constants
// for the iterative e^x Taylor engine.
package exp_taylor_engine_pkg;

  localparam int DEF_N    = 16;
  localparam int DEF_FRAC = 14;

  localparam int ONE    = 1 << DEF_FRAC;
  localparam int COEF_1 = ONE / 1;
  localparam int COEF_2 = ONE / 2;
  localparam int COEF_3 = ONE / 3;
  localparam int COEF_4 = ONE / 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_C = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/exp_taylor_engine_mux4.sv
// Plain 4:1 mux, N bits wide; used to pick the 1/k coefficient for each term.
module exp_taylor_engine_mux4 #(
  parameter int N = 16
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic [N-1:0] i2,
  input  logic [N-1:0] i3,
  output logic [N-1:0] y
);

  always_comb begin
    y = i0;
    case (sel)
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      2'd3:    y = i3;
      default: y = i0;
    endcase
  end

endmodule

// File: rtl/exp_taylor_engine.sv
// Iterative e^x = 1 + x + x^2/2! + x^3/3! + x^4/4! in unsigned fixed point,
// one shared multiplier alternating between "times x" and "times 1/k".
module exp_taylor_engine
  import exp_taylor_engine_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int FRAC = DEF_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         range_err
);

  localparam logic [N-1:0] ONE_Q = N'(ONE);

  state_e         state, state_next;
  logic [N-1:0]   x_reg, term_reg, sum_reg, result_reg;
  logic [1:0]     k_reg;
  logic           err_reg, done_reg, range_err_reg;
  logic [N-1:0]   coef;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] prod;
  logic [N-1:0]   prod_q;

  exp_taylor_engine_mux4 #(.N(N)) u_coef_mux (
    .sel (k_reg),
    .i0  (N'(COEF_1)),
    .i1  (N'(COEF_2)),
    .i2  (N'(COEF_3)),
    .i3  (N'(COEF_4)),
    .y   (coef)
  );

  // Truncating rescale: drop FRAC fraction bits, keep the low N bits.
  always_comb begin
    mul_b  = (state == MUL_X) ? x_reg : coef;
    prod   = {{N{1'b0}}, term_reg} * {{N{1'b0}}, mul_b};
    prod_q = N'(prod >> FRAC);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL_X;
      MUL_X:   state_next = MUL_C;
      MUL_C:   state_next = (k_reg == 2'd3) ? DONE : MUL_X;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_reg         <= '0;
      term_reg      <= '0;
      sum_reg       <= '0;
      k_reg         <= '0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      range_err_reg <= 1'b0;
    end else begin
      state    <= state_next;
      done_reg <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            // Out-of-range operands are clamped just below 1.0 and flagged.
            x_reg    <= (x_in >= ONE_Q) ? (ONE_Q - N'(1)) : x_in;
            err_reg  <= (x_in >= ONE_Q);
            term_reg <= ONE_Q;
            sum_reg  <= ONE_Q;
            k_reg    <= 2'd0;
          end
        end
        MUL_X: term_reg <= prod_q;
        MUL_C: begin
          term_reg <= prod_q;
          sum_reg  <= sum_reg + prod_q;
          if (k_reg != 2'd3) k_reg <= k_reg + 2'd1;
        end
        DONE: begin
          result_reg    <= sum_reg;
          range_err_reg <= err_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_reg;
  assign result    = result_reg;
  assign range_err = range_err_reg;

endmodule

// File: tb/tb_exp_taylor_engine.sv
// Directed bench for exp_taylor_engine: vector table plus hand-written
// sequences for reset, ignored starts, throughput and coefficient selection.
module tb_exp_taylor_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x_in = '0;
  logic        busy, done, range_err;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  exp_taylor_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] r;
    logic        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One full operation: start pulse, latency, busy length, result, pulse width.
  task automatic run_vec(input logic [15:0] x, input logic [15:0] r, input logic e);
    int lat = 0;
    int busy_cnt = 0;
    bit got = 0;
    x_in  = x;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1; lat = i; end
      else if (busy) busy_cnt++;
    end
    chk("latency", lat, 9);
    chk("busy_cycles", busy_cnt, 9);
    chk("result", result, r);
    chk("range_err", range_err, e);
    $display("vec x=%0d result=%0d range_err=%0b latency=%0d", x, result, range_err, lat);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int          sum_exp[4];
    int          coef_exp[4];
    int          done_times[$];
    int          cyc;
    int          extra;

    vecs[0] = '{16'd0,     16'd16384, 1'b0};
    vecs[1] = '{16'd8192,  16'd27007, 1'b0};
    vecs[2] = '{16'd4096,  16'd21036, 1'b0};
    vecs[3] = '{16'd1,     16'd16385, 1'b0};
    vecs[4] = '{16'd16383, 16'd44369, 1'b0};
    vecs[5] = '{16'd20000, 16'd44369, 1'b1};
    vecs[6] = '{16'd16384, 16'd44369, 1'b1};
    vecs[7] = '{16'd65535, 16'd44369, 1'b1};
    sum_exp  = '{24576, 26624, 26965, 27007};
    coef_exp = '{16384, 8192, 5461, 4096};

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_range_err", range_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) run_vec(vecs[v].x, vecs[v].r, vecs[v].e);

    // Walk one x=0.5 run cycle by cycle: sel follows k, coefficient and partial sums.
    x_in = 16'd8192; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      chk("mux_sel", dut.k_reg, (j - 1) / 2);
      if (j % 2 == 0) chk("mux_coef", dut.coef, coef_exp[(j - 1) / 2]);
      @(posedge clk); #1;
      if (j % 2 == 0) chk("partial_sum", dut.sum_reg, sum_exp[j / 2 - 1]);
    end
    $display("seq sel/coef/partial sums walked for x=8192");
    @(posedge clk); #1;
    chk("walk_done", done, 1);
    chk("walk_result", result, 27007);
    @(posedge clk); #1;

    // Starts while busy (and in the DONE cycle) with a new operand are ignored.
    x_in = 16'd8192; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    extra = 0;
    cyc = 0;
    for (int i = 1; i <= 25; i++) begin
      x_in  = 16'd0;
      start = (i == 3 || i == 8) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (done) begin
        extra++;
        if (cyc == 0) cyc = i;
        chk("ignored_start_result", result, 27007);
      end
    end
    start = 1'b0;
    chk("ignored_start_done_count", extra, 1);
    chk("ignored_start_latency", cyc, 9);
    $display("seq ignored starts: dones=%0d first_at=%0d result=%0d", extra, cyc, result);

    // Start held high: one result every 10 cycles.
    x_in = 16'd4096; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_times.push_back(i);
    end
    start = 1'b0;
    chk("b2b_done_count", done_times.size(), 4);
    if (done_times.size() >= 3) begin
      chk("b2b_interval_a", done_times[1] - done_times[0], 10);
      chk("b2b_interval_b", done_times[2] - done_times[1], 10);
    end
    chk("b2b_result", result, 21036);
    $display("seq back-to-back: dones=%0d", done_times.size());
    repeat (12) @(posedge clk);
    #1;

    // Asynchronous reset five cycles into a run.
    x_in = 16'd8192; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    chk("midrun_reset_result", result, 0);
    chk("midrun_reset_range_err", range_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    chk("post_reset_idle", extra, 0);
    $display("seq mid-run reset: outputs cleared, idle after release");
    run_vec(16'd0, 16'd16384, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
